// File: rtl/wrr_bus_arbiter_pkg.sv
// Shared definitions for the weighted round-robin bus arbiter:
// FSM state encoding and a constant-foldable ceiling-log2 helper.
package wrr_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  // Bits needed to hold values 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/wrr_bus_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request scanning
// ptr, ptr+1, ... modulo N.
module wrr_bus_arbiter_rr_pick
  import wrr_bus_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int ID_W = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    pick,
  output logic [ID_W-1:0] pick_id,
  output logic            any
);

  // Scan from farthest to nearest so the lowest rotated offset wins last.
  always_comb begin
    int idx;
    pick    = '0;
    pick_id = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
        pick_id   = ID_W'(idx);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wrr_bus_arbiter.sv
// Weighted round-robin arbiter: owner keeps the bus for up to its weight in
// done pulses, then rotates; a watchdog revokes owners that stall.
module wrr_bus_arbiter
  import wrr_bus_arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int WEIGHT_W = 4,
  parameter int TIMEOUT  = 16,
  localparam int ID_W    = clog2(N),
  localparam int WD_W    = clog2(TIMEOUT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          req,
  input  logic [N*WEIGHT_W-1:0] weight,
  input  logic                  done,
  output logic [N-1:0]          gnt,
  output logic                  gnt_valid,
  output logic [ID_W-1:0]       gnt_id,
  output logic                  timeout_err
);

  state_t                state;
  logic [ID_W-1:0]       ptr;
  logic [WEIGHT_W-1:0]   credit;
  logic [WD_W-1:0]       wd;

  logic [N-1:0]          pick;
  logic [ID_W-1:0]       pick_id;
  logic                  any;
  logic [WEIGHT_W-1:0]   pick_weight;
  logic [WEIGHT_W-1:0]   load_credit;
  logic                  owner_req;
  logic                  rel_done;
  logic                  rel_wd;
  logic                  release_now;
  logic [ID_W-1:0]       next_ptr;

  wrr_bus_arbiter_rr_pick #(.N(N)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .pick    (pick),
    .pick_id (pick_id),
    .any     (any)
  );

  assign pick_weight = weight[pick_id*WEIGHT_W +: WEIGHT_W];
  assign load_credit = (pick_weight == '0) ? WEIGHT_W'(1) : pick_weight;

  assign owner_req   = req[gnt_id];
  assign rel_done    = done && (credit == WEIGHT_W'(1));
  assign rel_wd      = !done && (wd == WD_W'(TIMEOUT - 1));
  assign release_now = rel_done || !owner_req || rel_wd;
  assign next_ptr    = (gnt_id == ID_W'(N - 1)) ? '0 : gnt_id + ID_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= '0;
      credit      <= '0;
      wd          <= '0;
      gnt         <= '0;
      gnt_valid   <= 1'b0;
      gnt_id      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE, TURN: begin
          if (any) begin
            state     <= GRANT;
            gnt       <= pick;
            gnt_valid <= 1'b1;
            gnt_id    <= pick_id;
            credit    <= load_credit;
            wd        <= '0;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (release_now) begin
            state       <= TURN;
            gnt         <= '0;
            gnt_valid   <= 1'b0;
            gnt_id      <= '0;
            ptr         <= next_ptr;
            wd          <= '0;
            // A withdrawn request is a normal release even if the watchdog expired.
            timeout_err <= rel_wd && owner_req;
          end else if (done) begin
            credit <= credit - WEIGHT_W'(1);
            wd     <= '0;
          end else if (wd != '1) begin
            wd <= wd + WD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wrr_bus_arbiter.sv
// Directed self-checking bench for wrr_bus_arbiter (N=4, WEIGHT_W=4, TIMEOUT=16).
module tb_wrr_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] weight;
  logic        done;
  logic [3:0]  gnt;
  logic        gnt_valid;
  logic [1:0]  gnt_id;
  logic        timeout_err;

  int passed;
  int total;

  wrr_bus_arbiter #(.N(4), .WEIGHT_W(4), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .weight      (weight),
    .done        (done),
    .gnt         (gnt),
    .gnt_valid   (gnt_valid),
    .gnt_id      (gnt_id),
    .timeout_err (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Outputs are sampled and inputs changed 1 time unit after each rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    req   = '0;
    done  = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset  = 1'b0;
    req    = 4'hF;
    done   = 1'b0;
    weight = 16'h2222;
    tick();
    tick();
    total++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got %b want %b", gnt, 4'b0000); else passed++;
    total++; if (gnt_valid !== 1'b0 || gnt_id !== 2'd0 || timeout_err !== 1'b0)
      $display("FAIL reset_outs got valid=%b id=%0d err=%b want 0 0 0", gnt_valid, gnt_id, timeout_err); else passed++;
    reset = 1'b1;
    tick();
    total++; if (gnt !== 4'b0001 || gnt_id !== 2'd0 || gnt_valid !== 1'b1)
      $display("FAIL reset_first_grant got gnt=%b id=%0d valid=%b want 0001 0 1", gnt, gnt_id, gnt_valid); else passed++;
    $display("reset: gnt=%b id=%0d after release", gnt, gnt_id);
  endtask

  task automatic test_weighted;
    logic [3:0] exp_gnt [13];
    logic [1:0] exp_id  [13];
    exp_gnt = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1};
    exp_id  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0};
    do_reset();
    weight = 16'h2222;
    req    = 4'hF;
    done   = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      total++; if (gnt !== exp_gnt[i] || gnt_id !== exp_id[i] || gnt_valid !== (exp_gnt[i] != 4'h0))
        $display("FAIL weighted_step%0d got gnt=%b id=%0d valid=%b want gnt=%b id=%0d", i, gnt, gnt_id, gnt_valid, exp_gnt[i], exp_id[i]);
      else passed++;
      $display("weighted: step %0d gnt=%b id=%0d", i, gnt, gnt_id);
    end
    req  = '0;
    done = 1'b0;
  endtask

  task automatic test_weight0;
    do_reset();
    weight = 16'h2202;
    req    = 4'b0010;
    tick();
    total++; if (gnt !== 4'b0010) $display("FAIL w0_grant got %b want %b", gnt, 4'b0010); else passed++;
    done = 1'b1;
    tick();
    done = 1'b0;
    total++; if (gnt !== 4'b0000 || timeout_err !== 1'b0)
      $display("FAIL w0_release got gnt=%b err=%b want 0000 0", gnt, timeout_err); else passed++;
    tick();
    total++; if (gnt !== 4'b0010 || gnt_id !== 2'd1)
      $display("FAIL w0_regrant got gnt=%b id=%0d want 0010 1", gnt, gnt_id); else passed++;
    $display("weight0: regrant gnt=%b", gnt);
    req = '0;
  endtask

  task automatic test_withdraw;
    do_reset();
    weight = 16'h0400;
    req    = 4'b0100;
    tick();
    total++; if (gnt !== 4'b0100) $display("FAIL wd_grant got %b want %b", gnt, 4'b0100); else passed++;
    done = 1'b1;
    tick();
    done = 1'b0;
    total++; if (gnt !== 4'b0100) $display("FAIL wd_hold got %b want %b", gnt, 4'b0100); else passed++;
    req = 4'b1011;
    tick();
    total++; if (gnt !== 4'b0000 || timeout_err !== 1'b0)
      $display("FAIL wd_drop got gnt=%b err=%b want 0000 0", gnt, timeout_err); else passed++;
    tick();
    total++; if (gnt !== 4'b1000 || gnt_id !== 2'd3)
      $display("FAIL wd_next_ptr got gnt=%b id=%0d want 1000 3", gnt, gnt_id); else passed++;
    $display("withdraw: next gnt=%b id=%0d", gnt, gnt_id);
    req = '0;
  endtask

  task automatic test_watchdog;
    do_reset();
    weight = 16'h2222;
    req    = 4'b0011;
    tick();
    total++; if (gnt !== 4'b0001) $display("FAIL tmo_grant got %b want %b", gnt, 4'b0001); else passed++;
    for (int i = 1; i < 16; i++) begin
      tick();
      total++; if (gnt !== 4'b0001 || timeout_err !== 1'b0)
        $display("FAIL tmo_wait%0d got gnt=%b err=%b want 0001 0", i, gnt, timeout_err); else passed++;
    end
    tick();
    total++; if (gnt !== 4'b0000 || timeout_err !== 1'b1)
      $display("FAIL tmo_revoke got gnt=%b err=%b want 0000 1", gnt, timeout_err); else passed++;
    tick();
    total++; if (gnt !== 4'b0010 || timeout_err !== 1'b0)
      $display("FAIL tmo_next got gnt=%b err=%b want 0010 0", gnt, timeout_err); else passed++;
    $display("watchdog: revoked owner 0, next gnt=%b", gnt);
    req = '0;
  endtask

  task automatic test_stray_done_and_reset;
    do_reset();
    weight = 16'h2222;
    done   = 1'b1;
    tick();
    done = 1'b0;
    total++; if (gnt !== 4'b0000 || gnt_valid !== 1'b0)
      $display("FAIL stray_idle got gnt=%b valid=%b want 0000 0", gnt, gnt_valid); else passed++;
    req = 4'hF;
    tick();
    total++; if (gnt !== 4'b0001) $display("FAIL stray_grant got %b want %b", gnt, 4'b0001); else passed++;
    done = 1'b1;
    tick();
    total++; if (gnt !== 4'b0001) $display("FAIL stray_credit got %b want %b", gnt, 4'b0001); else passed++;
    tick();
    done = 1'b0;
    tick();
    total++; if (gnt !== 4'b0010) $display("FAIL stray_rotate got %b want %b", gnt, 4'b0010); else passed++;
    #3;
    reset = 1'b0;
    #1;
    total++; if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0 || timeout_err !== 1'b0)
      $display("FAIL async_reset got gnt=%b valid=%b id=%0d err=%b want 0000 0 0 0", gnt, gnt_valid, gnt_id, timeout_err); else passed++;
    tick();
    reset = 1'b1;
    tick();
    total++; if (gnt !== 4'b0001) $display("FAIL reset_ptr got %b want %b", gnt, 4'b0001); else passed++;
    $display("stray/reset: gnt after mid-grant reset=%b", gnt);
    req = '0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b0;
    req    = '0;
    weight = '0;
    done   = 1'b0;
    test_reset();
    test_weighted();
    test_weight0();
    test_withdraw();
    test_watchdog();
    test_stray_done_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "simulation time limit");
  end

endmodule
